// File: rtl/rk4_slope_pipe.sv
// Three-stage RK4 slope unit: DY_DX = (x + h' - y - k') >>> SHIFT, with valid/ready flow control.
// Optional build macro RK_SLOPE_SAT_EN clamps DY_DX on overflow instead of wrapping.
module rk4_slope_pipe #(
   parameter int N     = 32,
   parameter int SHIFT = 1
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [N-1:0] X_IN,
   input  logic [N-1:0] Y_IN,
   input  logic [N-1:0] H_IN,
   input  logic [N-1:0] K_IN,
   input  logic         HALF_IN,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [N-1:0] DY_DX,
   output logic         K_sign,
   output logic         ovf,
   output logic         busy
);

   logic advance;

   logic s1_valid_q, s2_valid_q, s3_valid_q;

   logic signed [N:0]   x_e, y_e, h_e, k_e, hp_e, kp_e;
   logic signed [N:0]   sxh_d, syk_d, sxh_q, syk_q;
   logic signed [N+1:0] diff_d, diff_q, quo;
   logic [N-1:0]        dy_d, dy_q;
   logic                ks_d, ks_q, ovf_d, ovf_q;

   // The whole pipe moves as one; a stalled output freezes every stage, bubbles included.
   assign advance  = !s3_valid_q || out_ready;
   assign in_ready = advance;

   always_comb begin
      x_e   = {X_IN[N-1], X_IN};
      y_e   = {Y_IN[N-1], Y_IN};
      h_e   = {H_IN[N-1], H_IN};
      k_e   = {K_IN[N-1], K_IN};
      hp_e  = HALF_IN ? (h_e >>> 1) : h_e;
      kp_e  = HALF_IN ? (k_e >>> 1) : k_e;
      sxh_d = x_e + hp_e;
      syk_d = y_e + kp_e;
   end

   always_comb begin
      diff_d = {sxh_q[N], sxh_q} - {syk_q[N], syk_q};
   end

   always_comb begin
      quo   = diff_q >>> SHIFT;
      ks_d  = diff_q[N+1];
      // Representable iff the top three bits of the quotient agree.
      ovf_d = !((quo[N+1:N-1] == 3'b000) || (quo[N+1:N-1] == 3'b111));
`ifdef RK_SLOPE_SAT_EN
      if (ovf_d)
         dy_d = quo[N+1] ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
      else
         dy_d = quo[N-1:0];
`else
      dy_d = quo[N-1:0];
`endif
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         s1_valid_q <= 1'b0;
         s2_valid_q <= 1'b0;
         s3_valid_q <= 1'b0;
         sxh_q      <= '0;
         syk_q      <= '0;
         diff_q     <= '0;
         dy_q       <= '0;
         ks_q       <= 1'b0;
         ovf_q      <= 1'b0;
      end else if (advance) begin
         s1_valid_q <= in_valid;
         s2_valid_q <= s1_valid_q;
         s3_valid_q <= s2_valid_q;
         if (in_valid) begin
            sxh_q <= sxh_d;
            syk_q <= syk_d;
         end
         if (s1_valid_q)
            diff_q <= diff_d;
         if (s2_valid_q) begin
            dy_q  <= dy_d;
            ks_q  <= ks_d;
            ovf_q <= ovf_d;
         end
      end
   end

   assign out_valid = s3_valid_q;
   assign DY_DX     = dy_q;
   assign K_sign    = ks_q;
   assign ovf       = ovf_q;
   assign busy      = s1_valid_q || s2_valid_q || s3_valid_q;

endmodule

// File: doc/rk4_slope_pipe.md
Name: rk4_slope_pipe

Overview:
Pipelined, parametrised evaluator of the RK4 slope dy/dx = (x + h' - y - k') / 2^SHIFT. It accepts one (X, Y, H, K) operand set per cycle under valid/ready flow control. A per-transaction half-step mode halves H and K internally, so one unit serves all four RK4 stages (k1..k4). It sits between the RK4 step sequencer, which issues operand sets, and the accumulator, which consumes slopes.

Parameters:
N, 32, data width of all operands and result (two's complement, fixed point; binary point is the caller's concern)
SHIFT, 1, right-shift exponent of the divisor (1 gives /2), legal range 0..N-1

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous active-high reset
in_valid  input  1  operand set present
in_ready  output  1  unit accepts operand set this cycle
X_IN  input  N  x operand, signed
Y_IN  input  N  y operand, signed
H_IN  input  N  step term, signed
K_IN  input  N  previous-slope term, signed
HALF_IN  input  1  1 = use H_IN>>>1 and K_IN>>>1 (midpoint stages)
out_valid  output  1  result present
out_ready  input  1  downstream accepts result
DY_DX  output  N  slope result, signed
K_sign  output  1  sign of full-precision difference (1 = negative)
ovf  output  1  shifted result not representable in N bits
busy  output  1  any pipeline stage holds a valid transaction

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
- Reset: all stage valids 0, out_valid 0, DY_DX 0, K_sign 0, ovf 0, busy 0. Reset applied mid-stream discards all in-flight transactions on the next edge. in_ready is 1 in the cycle after reset deasserts.
- Pipeline: 3 register stages. Latency is 3 cycles from the accepting edge to out_valid with no backpressure. Throughput is 1 per cycle.
- S1: h' = HALF ? H>>>1 : H; k' = HALF ? K>>>1 : K (arithmetic shift, floor). Register sxh = X + h' and syk = Y + k', both sign-extended to N+1 bits.
- S2: register diff = sxh - syk at N+2 bits (exact, no overflow).
- S3: q = diff >>> SHIFT (arithmetic, floor toward -inf). Register:
  - K_sign = diff[N+1]
  - ovf = 1 when q lies outside [-2^(N-1), 2^(N-1)-1]
  - DY_DX = low N bits of q, or the saturated value (see Optional Feature)
- Handshake: advance = !out_valid || out_ready; in_ready = advance (combinational, no dependency on in_valid).
  - Transfer in: in_valid && in_ready. Transfer out: out_valid && out_ready.
  - When advance = 0, all stages hold, including bubbles. Outputs stay stable while out_valid && !out_ready.
  - Simultaneous in and out transfer in one cycle is legal and loses nothing.
- Ordering: strictly in order. No drop, no duplication.
- busy = OR of S1, S2 and S3 valid bits.

Optional Feature:
- Macro RK_SLOPE_SAT_EN.
- Defined: when ovf = 1, DY_DX clamps to 2^(N-1)-1 if q > 0, else to -2^(N-1).
- Undefined: DY_DX is the two's complement wrap of q (low N bits).
- ovf and K_sign are identical in both builds.

Test Plan:
- N=32, SHIFT=1, X=0x00010000, Y=0, H=0x00008000, K=0, HALF=0 -> 3 cycles later out_valid=1, DY_DX=0x0000C000, K_sign=0, ovf=0.
- X=0, Y=0x00020000, H=0, K=0, HALF=0 -> DY_DX=0xFFFF0000, K_sign=1, ovf=0.
- X=0, Y=0, H=0x00010000, K=0xFFFF0000, HALF=1 -> DY_DX=0x00008000, K_sign=0.
- X=H=0x7FFFFFFF, Y=K=0x80000000, HALF=0 -> ovf=1, K_sign=0:
  - without RK_SLOPE_SAT_EN: DY_DX=0xFFFFFFFF
  - with RK_SLOPE_SAT_EN: DY_DX=0x7FFFFFFF
- Stream 6 sets (X=1..6, others 0, SHIFT=0) with out_ready=0 for cycles 0-9 -> in_ready falls once S3 is full, 3 held, DY_DX stable. Then out_ready=1 -> outputs 1..6 in order, none lost.
- Reset pulse while 3 transactions in flight -> next cycle out_valid=0, busy=0, DY_DX=0. A new set accepted afterwards appears after 3 cycles.
